// File: rtl/pe_mesh_sequencer.sv
// pe_mesh_sequencer
//   Programs and runs a row of NUM_PE processing elements. Host commands
//   (CLEAR / CONFIG / RUN) arrive over cmd_valid/cmd_ready. CONFIG streams one
//   instruction/data beat per PE into the PE load ports, RUN raises the operand
//   feed strobe for N cycles and flags PE result cycles DRAIN_CYCLES later.
//   A shadow table of each PE's instruction is driven onto the lanes.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   cmd_valid/ready   host command handshake; cmd_op 00 CLEAR 01 CONFIG
//                     10 RUN 11 illegal; cmd_arg = RUN beat count
//   cfg_valid/ready   config beat handshake; cfg_instr / cfg_data payload
//   pe_reset          synchronous clear strobe to all PEs
//   pe_load           one-hot per-PE load strobe
//   pe_instruction    per-PE instruction lanes (lane i = bits [4i+3:4i])
//   pe_data           broadcast data, holds last loaded value
//   feed_valid        operand feeder strobe
//   out_valid         PE outputs valid
//   busy, done, err   status; done/err are single-cycle pulses
module pe_mesh_sequencer #(
  parameter int unsigned NUM_PE       = 16,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CNT_W-1:0]      cmd_arg,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_instr,
  input  logic [31:0]           cfg_data,
  output logic                  pe_reset,
  output logic [NUM_PE-1:0]     pe_load,
  output logic [4*NUM_PE-1:0]   pe_instruction,
  output logic [31:0]           pe_data,
  output logic                  feed_valid,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [3:0]  OP_DATA_ONLY = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CONFIG,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_PE-1:0][3:0]   shadow_q, shadow_d;
  logic [NUM_PE-1:0]        load_q, load_d;
  logic [3:0]               load_instr_q, load_instr_d;
  logic [31:0]              data_q, data_d;
  logic [DRAIN_CYCLES-1:0]  sr_q, sr_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [NUM_PE-1:0][3:0]   lanes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      load_q       <= '0;
      load_instr_q <= '0;
      data_q       <= '0;
      sr_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      load_q       <= load_d;
      load_instr_q <= load_instr_d;
      data_q       <= data_d;
      sr_q         <= sr_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    load_d       = '0;
    load_instr_d = load_instr_q;
    data_d       = data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    // Delay line: bit k holds feed_valid from k+1 cycles ago.
    sr_d         = DRAIN_CYCLES'({sr_q, feed_valid});

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            2'b00: state_d = S_CLEAR;
            2'b01: begin
              idx_d   = '0;
              state_d = S_CONFIG;
            end
            2'b10: begin
              if (cmd_arg != '0) begin
                cnt_d   = cmd_arg;
                state_d = S_RUN;
              end else begin
                done_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_CLEAR: begin
        shadow_d = '0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_CONFIG: begin
        if (cfg_valid) begin
          load_d       = NUM_PE'(1) << idx_q;
          load_instr_d = cfg_instr;
          data_d       = cfg_data;
          // Data-only opcode: the PE keeps its previous instruction.
          if (cfg_instr != OP_DATA_ONLY) shadow_d[idx_q] = cfg_instr;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_PE - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = CNT_W'(DRAIN_CYCLES);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The lane being loaded shows the incoming instruction for that cycle only;
  // afterwards it falls back to the shadow value.
  always_comb begin
    lanes = shadow_q;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (load_q[i]) lanes[i] = load_instr_q;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign cfg_ready      = (state_q == S_CONFIG);
  assign pe_reset       = (state_q == S_CLEAR);
  assign feed_valid     = (state_q == S_RUN);
  assign busy           = (state_q != S_IDLE);
  assign out_valid      = sr_q[DRAIN_CYCLES-1];
  assign pe_load        = load_q;
  assign pe_instruction = lanes;
  assign pe_data        = data_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_pe_mesh_sequencer.sv
// Bench for pe_mesh_sequencer: timeline-based reference model plus pinned
// literal expectations for the directed scenarios.
module tb_pe_mesh_sequencer;
  localparam int NPE  = 4;
  localparam int D    = 2;
  localparam int CW   = 16;
  localparam int MAXC = 4000;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid, cmd_ready;
  logic [1:0]      cmd_op;
  logic [CW-1:0]   cmd_arg;
  logic            cfg_valid, cfg_ready;
  logic [3:0]      cfg_instr;
  logic [31:0]     cfg_data;
  logic            pe_reset;
  logic [NPE-1:0]  pe_load;
  logic [4*NPE-1:0] pe_instruction;
  logic [31:0]     pe_data;
  logic            feed_valid, out_valid, busy, done, err;

  always #5 clk = ~clk;

  pe_mesh_sequencer #(.NUM_PE(NPE), .DRAIN_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_instr(cfg_instr), .cfg_data(cfg_data),
    .pe_reset(pe_reset), .pe_load(pe_load), .pe_instruction(pe_instruction),
    .pe_data(pe_data), .feed_valid(feed_valid), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int free_at  = 0;

  // Expected outputs per cycle index.
  bit               e_busy [MAXC];
  bit               e_cfgr [MAXC];
  bit               e_rst  [MAXC];
  bit               e_feed [MAXC];
  bit               e_out  [MAXC];
  bit               e_done [MAXC];
  bit               e_err  [MAXC];
  bit [NPE-1:0]     e_load [MAXC];
  bit [3:0]         e_ovr  [MAXC];
  bit [31:0]        e_data [MAXC];
  bit [4*NPE-1:0]   e_shadow [MAXC];
  bit [3:0]         tbl [NPE];
  bit [4*NPE-1:0]   exp_lanes;

  // Monitor used by the RUN N=5 scenario.
  int feed_n, out_n, first_feed, first_out, last_out, done_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit [4*NPE-1:0] pack_tbl();
    bit [4*NPE-1:0] r;
    for (int i = 0; i < NPE; i++) r[4*i +: 4] = tbl[i];
    return r;
  endfunction

  task automatic set_shadow_from(input int c);
    bit [4*NPE-1:0] v;
    v = pack_tbl();
    for (int k = c; k < MAXC; k++) e_shadow[k] = v;
  endtask

  task automatic set_data_from(input int c, input bit [31:0] v);
    for (int k = c; k < MAXC; k++) e_data[k] = v;
  endtask

  task automatic zero_from(input int c);
    for (int i = 0; i < NPE; i++) tbl[i] = '0;
    for (int k = c; k < MAXC; k++) begin
      e_busy[k] = 0; e_cfgr[k] = 0; e_rst[k] = 0; e_feed[k] = 0; e_out[k] = 0;
      e_done[k] = 0; e_err[k] = 0; e_load[k] = '0; e_ovr[k] = '0;
      e_data[k] = '0; e_shadow[k] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      exp_lanes = e_shadow[cyc];
      for (int i = 0; i < NPE; i++)
        if (e_load[cyc][i]) exp_lanes[4*i +: 4] = e_ovr[cyc];
      chk("busy",           64'(busy),           64'(e_busy[cyc]));
      chk("cmd_ready",      64'(cmd_ready),      64'(!e_busy[cyc]));
      chk("cfg_ready",      64'(cfg_ready),      64'(e_cfgr[cyc]));
      chk("pe_reset",       64'(pe_reset),       64'(e_rst[cyc]));
      chk("pe_load",        64'(pe_load),        64'(e_load[cyc]));
      chk("pe_data",        64'(pe_data),        64'(e_data[cyc]));
      chk("pe_instruction", 64'(pe_instruction), 64'(exp_lanes));
      chk("feed_valid",     64'(feed_valid),     64'(e_feed[cyc]));
      chk("out_valid",      64'(out_valid),      64'(e_out[cyc]));
      chk("done",           64'(done),           64'(e_done[cyc]));
      chk("err",            64'(err),            64'(e_err[cyc]));
    end
    if (feed_valid) begin
      feed_n++;
      if (first_feed < 0) first_feed = cyc;
    end
    if (out_valid) begin
      out_n++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (done && done_c < 0) done_c = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom);
    cmd_arg   = CW'($urandom);
  endtask

  task automatic noise_cfg();
    cfg_valid = 1'($urandom_range(0, 1));
    cfg_instr = 4'($urandom);
    cfg_data  = $urandom;
  endtask

  // Lets the DUT run until the model says it is idle; the inputs driven
  // meanwhile must all be ignored.
  task automatic wait_free();
    while (cyc < free_at) begin
      noise_cmd();
      noise_cfg();
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input bit [1:0] op, input bit [CW-1:0] arg);
    int t;
    wait_free();
    t = cyc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    noise_cfg();
    case (op)
      2'b00: begin
        e_rst[t+1] = 1; e_busy[t+1] = 1; e_done[t+2] = 1;
        for (int i = 0; i < NPE; i++) tbl[i] = '0;
        set_shadow_from(t + 2);
        free_at = t + 2;
      end
      2'b01: free_at = t + 1;
      2'b10: begin
        if (arg == 0) begin
          e_done[t+1] = 1;
          free_at = t + 1;
        end else begin
          for (int k = 1; k <= int'(arg); k++) begin
            e_feed[t+k] = 1;
            e_out[t+k+D] = 1;
          end
          for (int k = 1; k <= int'(arg) + D; k++) e_busy[t+k] = 1;
          e_done[t+int'(arg)+D+1] = 1;
          free_at = t + int'(arg) + D + 1;
        end
      end
      default: begin
        e_err[t+1] = 1;
        free_at = t + 1;
      end
    endcase
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    int c;
    c = cyc;
    cmd_valid = 1'b0;
    cfg_valid = 1'b0;
    reset = 1'b0;
    zero_from(c);
    #1;
    chk("async_rst_busy", 64'(busy),       64'(0));
    chk("async_rst_feed", 64'(feed_valid), 64'(0));
    chk("async_rst_out",  64'(out_valid),  64'(0));
    chk("async_rst_load", 64'(pe_load),    64'(0));
    tick();
    tick();
    reset = 1'b1;
    free_at = cyc;
  endtask

  task automatic config_seq(input bit [3:0] ins [NPE], input bit [31:0] dat [NPE],
                            input int gaps [NPE], input int abort_n);
    int i;
    int g;
    i = 0;
    issue(2'b01, CW'($urandom));
    while (i < NPE) begin
      g = gaps[i];
      while (g > 0) begin
        e_busy[cyc] = 1; e_cfgr[cyc] = 1;
        noise_cmd();
        cfg_valid = 1'b0;
        cfg_instr = 4'($urandom);
        cfg_data  = $urandom;
        tick();
        g--;
      end
      e_busy[cyc] = 1; e_cfgr[cyc] = 1;
      noise_cmd();
      cfg_valid = 1'b1;
      cfg_instr = ins[i];
      cfg_data  = dat[i];
      e_load[cyc+1] = NPE'(1) << i;
      e_ovr[cyc+1]  = ins[i];
      set_data_from(cyc + 1, dat[i]);
      if (ins[i] != 4'b0010) begin
        tbl[i] = ins[i];
        set_shadow_from(cyc + 1);
      end
      if (i == NPE - 1) e_done[cyc+1] = 1;
      i++;
      tick();
      if (abort_n > 0 && i == abort_n) begin
        do_reset();
        return;
      end
    end
    cfg_valid = 1'b0;
    cmd_valid = 1'b0;
    free_at = cyc;
  endtask

  bit [3:0]  ins [NPE];
  bit [31:0] dat [NPE];
  int        gaps [NPE];
  int        r;

  initial begin
    #(MAXC * 10 - 200);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_arg = 0;
    cfg_valid = 0; cfg_instr = 0; cfg_data = 0;
    feed_n = 0; out_n = 0; first_feed = -1; first_out = -1; last_out = -1; done_c = -1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_busy",  64'(busy),           64'(0));
    chk("reset_instr", 64'(pe_instruction), 64'(0));
    chk("reset_ready", 64'(cmd_ready),      64'(1));
    chk_en = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    free_at = cyc;

    // CLEAR after reset
    issue(2'b00, CW'($urandom));
    @(negedge clk);
    chk("pin_clear_pe_reset", 64'(pe_reset), 64'(1));
    tick();
    @(negedge clk);
    chk("pin_clear_done",  64'(done),           64'(1));
    chk("pin_clear_lanes", 64'(pe_instruction), 64'(0));
    tick();

    // Directed CONFIG, continuous beats
    ins = '{4'b0000, 4'b0001, 4'b1010, 4'b0011};
    dat = '{32'hA, 32'hB, 32'hC, 32'hD};
    gaps = '{0, 0, 0, 0};
    config_seq(ins, dat, gaps, 0);
    @(negedge clk);
    chk("pin_cfg_lanes", 64'(pe_instruction), 64'h3A10);
    chk("pin_cfg_data",  64'(pe_data),        64'hD);
    chk("pin_cfg_load",  64'(pe_load),        64'b1000);
    chk("pin_cfg_done",  64'(done),           64'(1));
    tick();

    // Data-only opcode on PE2 with a 3-cycle stall before it
    ins = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
    dat = '{32'h10, 32'h11, 32'h5, 32'h13};
    gaps = '{0, 0, 3, 0};
    config_seq(ins, dat, gaps, 0);
    @(negedge clk);
    chk("pin_dataonly_lanes", 64'(pe_instruction), 64'h3A10);
    tick();

    // RUN N=5
    feed_n = 0; out_n = 0; first_feed = -1; first_out = -1; last_out = -1; done_c = -1;
    issue(2'b10, 16'd5);
    wait_free();
    cfg_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pin_run5_feed_cnt", 64'(feed_n), 64'(5));
    chk("pin_run5_out_cnt",  64'(out_n),  64'(5));
    chk("pin_run5_latency",  64'(first_out - first_feed), 64'(2));
    chk("pin_run5_done_gap", 64'(done_c - last_out),      64'(1));
    tick();

    // RUN N=0
    issue(2'b10, 16'd0);
    @(negedge clk);
    chk("pin_run0_done", 64'(done),       64'(1));
    chk("pin_run0_feed", 64'(feed_valid), 64'(0));
    tick();

    // Illegal op
    issue(2'b11, CW'($urandom));
    @(negedge clk);
    chk("pin_illegal_err",  64'(err),  64'(1));
    chk("pin_illegal_busy", 64'(busy), 64'(0));
    tick();

    // Random command mix
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 1) issue(2'b00, CW'($urandom));
      else if (r < 5) begin
        for (int i = 0; i < NPE; i++) begin
          ins[i]  = ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'($urandom);
          dat[i]  = $urandom;
          gaps[i] = $urandom_range(0, 2);
        end
        config_seq(ins, dat, gaps, 0);
      end
      else if (r < 9) issue(2'b10, CW'($urandom_range(0, 12)));
      else issue(2'b11, CW'($urandom));
    end

    // Reset in the middle of RUN, with a non-zero table beforehand
    ins = '{4'b0111, 4'b0001, 4'b1010, 4'b0011};
    dat = '{32'h21, 32'h22, 32'h23, 32'h24};
    gaps = '{0, 1, 0, 0};
    config_seq(ins, dat, gaps, 0);
    issue(2'b10, 16'd20);
    repeat (4) begin
      noise_cmd();
      noise_cfg();
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("pin_rst_tbl_cleared", 64'(pe_instruction), 64'(0));
    tick();

    // Reset in the middle of CONFIG: partial program discarded
    ins = '{4'b0101, 4'b0110, 4'b1000, 4'b1001};
    dat = '{32'h31, 32'h32, 32'h33, 32'h34};
    gaps = '{0, 0, 0, 0};
    config_seq(ins, dat, gaps, 2);
    @(negedge clk);
    chk("pin_cfg_abort_lanes", 64'(pe_instruction), 64'(0));
    tick();

    // Follow-up traffic after the aborts
    issue(2'b10, 16'd3);
    ins = '{4'b1111, 4'b0010, 4'b0100, 4'b0001};
    dat = '{32'h41, 32'h42, 32'h43, 32'h44};
    gaps = '{1, 0, 2, 0};
    config_seq(ins, dat, gaps, 0);
    issue(2'b00, CW'($urandom));
    wait_free();
    cfg_valid = 1'b0;
    repeat (4) tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pe_mesh_sequencer.md
Name: pe_mesh_sequencer

Overview:
Controller that programs and runs a row of NUM_PE processing elements in the Accelerant mesh. It accepts host commands (CLEAR, CONFIG, RUN) over a valid/ready interface and streams per-PE instruction/data beats into each PE's load port. It then drives the compute phase by asserting operand-feed strobes for N cycles and flags result-valid cycles after the PE pipeline latency. It also keeps a shadow table of each PE's configured instruction and drives it onto the PE instruction lanes during RUN.

Parameters:
NUM_PE, 16, number of PEs sequenced (≥2)
DRAIN_CYCLES, 2, PE latency from operand-in to out_to_switch valid (≥1)
CNT_W, 16, width of RUN beat counter

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  sequencer accepts command
cmd_op  in  2  00 CLEAR, 01 CONFIG, 10 RUN, 11 illegal
cmd_arg  in  CNT_W  RUN beat count N; ignored for other ops
cfg_valid  in  1  config beat valid
cfg_ready  out  1  config beat accepted
cfg_instr  in  4  instruction for current PE
cfg_data  in  32  internal_data_in value for current PE
pe_reset  out  1  active-high synchronous clear to all PEs
pe_load  out  NUM_PE  per-PE load strobe, at most one bit set
pe_instruction  out  4*NUM_PE  per-PE instruction lanes; lane i = bits [4i+3:4i]
pe_data  out  32  broadcast internal_data_in
feed_valid  out  1  operand feeder pushes a/b/c this cycle
out_valid  out  1  PE outputs valid this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-command pulse

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0. Shadow table, index, counters, and the feed shift register are 0. Reset does not pulse pe_reset; software issues CLEAR after reset.
- States: IDLE, CLEAR, CONFIG, RUN, DRAIN. cmd_ready=1 only in IDLE. cfg_ready=1 only in CONFIG. cfg beats outside CONFIG are ignored.
- IDLE, on cmd_valid (handshake cycle t):
  - CLEAR: go to CLEAR.
  - CONFIG: idx←0, go to CONFIG.
  - RUN with N>0: cnt←N, go to RUN.
  - RUN with N=0: done=1 at t+1, stay IDLE.
  - op 11: err=1 at t+1, stay IDLE.
- CLEAR (1 cycle): pe_reset=1, shadow table←0. Next cycle: IDLE with done=1.
- CONFIG:
  - Beat accepted at cycle t → at t+1: pe_load[idx]=1, pe_data=cfg_data, lane idx of pe_instruction=cfg_instr. All other lanes hold shadow values.
  - Shadow update: table[idx]←cfg_instr unless cfg_instr==4'b0010. Opcode 0010 is data-only; PE and shadow keep the old configuration.
  - Rate is at most one beat per cycle. cfg_valid=0 stalls with no pe_load.
  - idx increments per beat. The beat with idx=NUM_PE-1 returns to IDLE; done=1 in the same cycle as the last pe_load.
  - pe_data holds its last value when not loading.
- RUN: feed_valid=1 for exactly N consecutive cycles, starting the cycle after the handshake. pe_instruction = shadow table. After N cycles go to DRAIN.
- out_valid = feed_valid delayed by DRAIN_CYCLES (shift register). It is high for exactly N cycles.
- DRAIN: DRAIN_CYCLES cycles. If feed occupies cycles k..k+N-1, out_valid is high for k+D..k+D+N-1. done=1 at k+N+D, with state IDLE in that cycle.
- pe_load=0 and pe_reset=0 in every state except their stated cycles. feed_valid=0 outside RUN.
- done and err are never simultaneous. A new command is accepted in the same cycle done pulses (IDLE, cmd_ready=1).
- Async reset mid-CONFIG or mid-RUN: outputs drop to 0 immediately; the partial program is discarded.

Test Plan:
- Reset, then CLEAR → pe_reset high exactly 1 cycle; done next cycle; all pe_instruction lanes 0.
- NUM_PE=4, CONFIG with beats (0000,A),(0001,B),(1010,C),(0011,D), cfg_valid continuous → pe_load 0001,0010,0100,1000 on consecutive cycles. pe_data=A..D; done with last load; lanes = 3,A,1,0 (lane3..0).
- CONFIG with beat 2 = (0010,0x5) after prior table value 1010 → pe_load[2] with pe_data 0x5, lane 2 shows 0010 during load then reverts to 1010. cfg_valid gap of 3 cycles inserts no loads.
- RUN N=5, DRAIN_CYCLES=2 → feed_valid high 5 cycles, out_valid high 5 cycles starting 2 cycles after the first feed; done exactly 1 cycle after the last out_valid; RUN N=0 → done next cycle, no feed_valid.
- cmd_op=11 → err 1 cycle, no state change. Commands during RUN see cmd_ready=0. Reset pulled low mid-RUN → feed_valid/out_valid/busy 0 immediately, table cleared.
